// File: rtl/lcd_tile_writer.sv
// Serialises one LCD tile write: CASET/PASET/RAMWR header, then a solid
// RGB565 fill, over a valid/ready byte stream to the serial transmitter.
module lcd_tile_writer #(
    parameter int TILE_W = 20,
    parameter int TILE_H = 20
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [15:0] col_start,
    input  logic [15:0] row_start,
    input  logic [15:0] color,
    output logic        busy,
    output logic        done,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_dc,
    input  logic        tx_ready
);
    localparam int NBYTES = 2 * TILE_W * TILE_H;
    localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {IDLE, HDR, PIX} state_t;

    state_t        state_q, state_d;
    logic [3:0]    hdr_idx_q, hdr_idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   sc_q, sc_d, ec_q, ec_d, sp_q, sp_d, ep_q, ep_d;
    logic [15:0]   color_q, color_d;
    logic          done_q, done_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            hdr_idx_q <= '0;
            cnt_q     <= '0;
            sc_q      <= '0;
            ec_q      <= '0;
            sp_q      <= '0;
            ep_q      <= '0;
            color_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_idx_q <= hdr_idx_d;
            cnt_q     <= cnt_d;
            sc_q      <= sc_d;
            ec_q      <= ec_d;
            sp_q      <= sp_d;
            ep_q      <= ep_d;
            color_q   <= color_d;
            done_q    <= done_d;
        end
    end

    // Byte presented depends only on registered state, so it holds through stalls.
    always_comb begin
        state_d   = state_q;
        hdr_idx_d = hdr_idx_q;
        cnt_d     = cnt_q;
        sc_d      = sc_q;
        ec_d      = ec_q;
        sp_d      = sp_q;
        ep_d      = ep_q;
        color_d   = color_q;
        done_d    = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        tx_dc     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sc_d      = col_start;
                    ec_d      = col_start + 16'(TILE_W - 1);
                    sp_d      = row_start;
                    ep_d      = row_start + 16'(TILE_H - 1);
                    color_d   = color;
                    hdr_idx_d = '0;
                    state_d   = HDR;
                end
            end
            HDR: begin
                tx_valid = 1'b1;
                tx_dc    = 1'b1;
                case (hdr_idx_q)
                    4'd0:    begin tx_data = 8'h2A; tx_dc = 1'b0; end
                    4'd1:    tx_data = sc_q[15:8];
                    4'd2:    tx_data = sc_q[7:0];
                    4'd3:    tx_data = ec_q[15:8];
                    4'd4:    tx_data = ec_q[7:0];
                    4'd5:    begin tx_data = 8'h2B; tx_dc = 1'b0; end
                    4'd6:    tx_data = sp_q[15:8];
                    4'd7:    tx_data = sp_q[7:0];
                    4'd8:    tx_data = ep_q[15:8];
                    4'd9:    tx_data = ep_q[7:0];
                    default: begin tx_data = 8'h2C; tx_dc = 1'b0; end
                endcase
                if (tx_ready) begin
                    if (hdr_idx_q == 4'd10) begin
                        cnt_d   = '0;
                        state_d = PIX;
                    end else begin
                        hdr_idx_d = hdr_idx_q + 4'd1;
                    end
                end
            end
            PIX: begin
                tx_valid = 1'b1;
                tx_dc    = 1'b1;
                tx_data  = cnt_q[0] ? color_q[7:0] : color_q[15:8];
                if (tx_ready) begin
                    if (cnt_q == CW'(NBYTES - 1)) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_lcd_tile_writer.sv
// Directed sequence of tile writes with randomized coordinates/colour/ready,
// checked byte-by-byte against an expected stream built from the tile rules.
module tb_lcd_tile_writer;
    localparam int W = 20;
    localparam int H = 20;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [15:0] col_start, row_start, color;
    logic        busy, done, tx_valid, tx_dc, tx_ready;
    logic [7:0]  tx_data;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    lcd_tile_writer #(.TILE_W(W), .TILE_H(H)) dut (
        .clk(clk), .rstn(rstn), .start(start),
        .col_start(col_start), .row_start(row_start), .color(color),
        .busy(busy), .done(done), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_dc(tx_dc), .tx_ready(tx_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Expected stream as {dc, byte}: header then W*H pixels, high byte first.
    task automatic build(input logic [15:0] c, r, col, output logic [8:0] q[$]);
        logic [15:0] ec, ep;
        ec = c + 16'(W - 1);
        ep = r + 16'(H - 1);
        q = {};
        q.push_back({1'b0, 8'h2A});
        q.push_back({1'b1, c[15:8]});  q.push_back({1'b1, c[7:0]});
        q.push_back({1'b1, ec[15:8]}); q.push_back({1'b1, ec[7:0]});
        q.push_back({1'b0, 8'h2B});
        q.push_back({1'b1, r[15:8]});  q.push_back({1'b1, r[7:0]});
        q.push_back({1'b1, ep[15:8]}); q.push_back({1'b1, ep[7:0]});
        q.push_back({1'b0, 8'h2C});
        for (int i = 0; i < W * H; i++) begin
            q.push_back({1'b1, col[15:8]});
            q.push_back({1'b1, col[7:0]});
        end
    endtask

    // mode 0: ready=1, 1: random ready, 2: ready=1 with stray starts at cycles 5/400.
    // abort_at >= 0: pull reset while that byte index is being presented.
    task automatic run_tile(input logic [15:0] c, r, col, input int mode, input int abort_at);
        logic [8:0] q[$];
        logic [8:0] prev;
        int idx, cyc, stalls;
        bit stalled;
        build(c, r, col, q);
        col_start = c; row_start = r; color = col; start = 1'b1; tx_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cyc = 1; idx = 0; stalls = 0; stalled = 0; prev = '0;
        while (idx < q.size() && cyc < 20000) begin
            col_start = 16'($urandom); row_start = 16'($urandom); color = 16'($urandom);
            start    = (mode == 2) && (cyc == 5 || cyc == 400);
            tx_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (idx == abort_at) begin
                rstn = 1'b0; #1;
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_valid", tx_valid, 0);
                check("rst_data", tx_data, 0);
                check("rst_dc", tx_dc, 0);
                @(posedge clk); #1;
                check("rst_hold_done", done, 0);
                check("rst_hold_busy", busy, 0);
                rstn = 1'b1; start = 1'b0;
                return;
            end
            check("valid", tx_valid, 1);
            check("busy", busy, 1);
            check("done_early", done, 0);
            check($sformatf("byte%0d", idx), {tx_dc, tx_data}, q[idx]);
            if (stalled) check("stall_hold", {tx_dc, tx_data}, prev);
            stalled = !tx_ready;
            prev = {tx_dc, tx_data};
            if (tx_ready) idx++; else stalls++;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check("xfer_count", idx, q.size());
        check("done_cycle", cyc, q.size() + stalls + 1);
        check("done", done, 1);
        check("busy_end", busy, 0);
        check("valid_end", tx_valid, 0);
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; tx_ready = 1'b0;
        col_start = '0; row_start = '0; color = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_valid", tx_valid, 0);
        check("reset_data", tx_data, 0);
        check("reset_dc", tx_dc, 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        run_tile(16'd0, 16'd0, 16'hF800, 0, -1);
        // back-to-back: start issued in the done cycle
        run_tile(16'd220, 16'd300, 16'h1234, 0, -1);
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
        check("idle_valid", tx_valid, 0);

        run_tile(16'($urandom), 16'($urandom), 16'($urandom), 1, -1);
        @(posedge clk); #1;
        run_tile(16'($urandom), 16'($urandom), 16'hF800, 1, -1);
        @(posedge clk); #1;
        run_tile(16'h0123, 16'h0045, 16'($urandom), 2, -1);
        @(posedge clk); #1;
        check("no_extra_done", done, 0);
        check("no_restart", busy, 0);
        run_tile(16'hFFF0, 16'hFFFF, 16'h5A5A, 0, -1);
        @(posedge clk); #1;
        run_tile(16'd10, 16'd20, 16'h07E0, 0, 111);
        @(posedge clk); #1;
        check("post_abort_idle", busy, 0);
        run_tile(16'd30, 16'd40, 16'hABCD, 1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
